rgb_pixel_packer: RTL
=====================

Name: rgb_pixel_packer

Overview:
- Upstream feeder for the DVI output stage.
- Accepts the 8-bit byte stream delivered by the network client, packs each group of 3 bytes into one 24-bit RGB pixel, and buffers pixels in a small FIFO.
- Presents pixels on a valid/ready interface that drives the DVI stage's pixel_data/pixel_valid/ready ports.
- Tracks pixel position within a frame and flags start/end of frame.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 4.
- FRAME_PIXELS, 307200, pixels per frame (640x480).

Ports:
- clk_100  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset.
- byte_data  input  8  incoming byte from client.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_ready  output  1  packer can accept a byte.
- pixel_data  output  24  packed pixel {R,G,B}, to DVI stage.
- pixel_valid  output  1  pixel_data valid.
- pixel_ready  input  1  DVI stage ready (its ready output).
- pixel_sof  output  1  current output pixel is pixel 0 of a frame.
- pixel_eof  output  1  current output pixel is pixel FRAME_PIXELS-1.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  pixels currently held.
- resync  input  1  synchronous pulse: discard the partial pixel and restart the frame count.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, except byte_ready, which is 1 after reset releases.
  - FIFO empty; byte phase = 0; input and output frame counters = 0.
- Input handshake:
  - A byte is accepted when byte_valid && byte_ready.
  - byte_ready = !(fifo full) || (phase != 2). Bytes 0 and 1 of a pixel are always accepted into the holding registers; byte 2 is accepted only when the FIFO has space or a pop occurs in the same cycle.
- Packing state machine, phase 0 -> 1 -> 2 -> 0, advancing on each accepted byte:
  - Phase 0: byte latched to R.
  - Phase 1: byte latched to G.
  - Phase 2: byte is B; {R,G,byte} is pushed into the FIFO in the same cycle, tagged with sof = (in_cnt==0) and eof = (in_cnt==FRAME_PIXELS-1).
  - in_cnt increments on each push and wraps to 0 after FRAME_PIXELS-1.
- Output:
  - FIFO head is registered onto pixel_data/pixel_sof/pixel_eof.
  - pixel_valid = FIFO not empty.
  - A transfer occurs when pixel_valid && pixel_ready; the next entry is shown the following cycle.
  - Outputs are stable while pixel_valid && !pixel_ready.
- Latency: the third byte accepted at cycle N gives pixel_valid=1 at cycle N+1 when the FIFO was empty.
- Simultaneous push and pop:
  - fifo_level unchanged.
  - Allowed when full, so full throughput is one pixel per 3 byte cycles.
- Full: byte_ready drops only at phase 2; no byte is ever dropped.
- Empty: pixel_valid=0; pixel_data holds its last value; pixel_ready is ignored.
- resync (sampled at clk_100):
  - phase <- 0; held R/G discarded; in_cnt <- 0.
  - FIFO contents are kept.
  - A byte presented in the same cycle is not accepted: byte_ready is forced 0 for that cycle.
- Pointer arithmetic: $clog2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty; level = wptr - rptr modulo width.
- Reset asserted mid-operation: immediate clear, including any partial pixel; pixel_valid drops asynchronously.

Optional Feature:
- Macro: PIXEL_BGR_ORDER_EN.
- Defined: phase-0 byte is B, phase-1 byte is G, phase-2 byte is R; the packed word is still output as {R,G,B}.
- Undefined: R,G,B arrival order as in Behaviour.
- No timing difference either way.

Test Plan:
- Reset then bytes 0x11,0x22,0x33 with pixel_ready=1 -> pixel_valid=1 one cycle after the third byte, pixel_data=0x112233, pixel_sof=1, fifo_level=1 then 0.
- pixel_ready=0, stream 16 pixels (48 bytes) with FIFO_DEPTH=16, then 2 more bytes and a third -> fifo_level=16; byte_ready=1 for the first two extra bytes, 0 at phase 2; raising pixel_ready drains in order and the 17th pixel is accepted.
- FRAME_PIXELS=4 override, 9 pixels streamed -> sof on pixels 0 and 4 and 8, eof on pixels 3 and 7.
- Send 0xAA,0xBB then pulse resync, then 0x01,0x02,0x03 -> single pixel 0x010203 with sof=1; 0xAA/0xBB never appear.
- Full FIFO with continuous byte_valid and pixel_ready toggling 1/0 every cycle -> no lost or duplicated pixel; output sequence matches the packed input sequence; fifo_level never exceeds 16.
- PIXEL_BGR_ORDER_EN defined, bytes 0x33,0x22,0x11 -> pixel_data=0x112233.

Source files
------------

// File: rtl/rgb_pixel_packer.sv
// rgb_pixel_packer: packs a byte stream into 24-bit RGB pixels, buffers them and tags frame start/end.
// Define PIXEL_BGR_ORDER_EN to accept bytes in B,G,R arrival order (output stays {R,G,B}).
module rgb_pixel_packer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                        clk_100,
    input  logic                        reset,
    input  logic [7:0]                  byte_data,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    output logic [23:0]                 pixel_data,
    output logic                        pixel_valid,
    input  logic                        pixel_ready,
    output logic                        pixel_sof,
    output logic                        pixel_eof,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    input  logic                        resync
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    typedef enum logic [1:0] {PH0, PH1, PH2} phase_t;
    phase_t          phase_q, phase_d;
    logic [7:0]      h0_q, h0_d, h1_q, h1_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [25:0]     mem_q [FIFO_DEPTH];
    logic [25:0]     head_q, head_d, push_word;
    logic [23:0]     packed_px;
    logic            full, accept, push, pop, last_px;
    always_comb begin
        fifo_level  = wptr_q - rptr_q;
        full        = fifo_level == (AW+1)'(FIFO_DEPTH);
        pixel_valid = wptr_q != rptr_q;
        pop         = pixel_valid && pixel_ready;
        // a pop in the same cycle frees the slot the third byte needs
        byte_ready  = reset && !resync && (!full || phase_q != PH2 || pop);
        accept      = byte_valid && byte_ready;
        push        = accept && phase_q == PH2;
        last_px     = cnt_q == CW'(FRAME_PIXELS - 1);
`ifdef PIXEL_BGR_ORDER_EN
        packed_px   = {byte_data, h1_q, h0_q};
`else
        packed_px   = {h0_q, h1_q, byte_data};
`endif
        push_word   = {cnt_q == '0, last_px, packed_px};
        phase_d     = resync ? PH0 : !accept ? phase_q : phase_q == PH2 ? PH0 : phase_t'(phase_q + 2'd1);
        h0_d        = accept && phase_q == PH0 ? byte_data : h0_q;
        h1_d        = accept && phase_q == PH1 ? byte_data : h1_q;
        cnt_d       = resync ? '0 : !push ? cnt_q : last_px ? '0 : cnt_q + CW'(1);
        wptr_d      = wptr_q + (AW+1)'(push);
        rptr_d      = rptr_q + (AW+1)'(pop);
        // the head register shows the entry at rptr_d; bypass when that entry is being written now
        head_d      = wptr_d == rptr_d ? head_q :
                      (push && rptr_d == wptr_q) ? push_word : mem_q[rptr_d[AW-1:0]];
        pixel_data  = head_q[23:0];
        pixel_sof   = head_q[25];
        pixel_eof   = head_q[24];
    end
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            phase_q <= PH0;
            h0_q    <= '0;
            h1_q    <= '0;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            head_q  <= '0;
        end else begin
            phase_q <= phase_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            head_q  <= head_d;
        end
    end
    always_ff @(posedge clk_100) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= push_word;
    end
endmodule
